// File: rtl/clk_ref_gen.sv
// clk_ref_gen: transmit side of the reference-clock link.
// Produces the divided square wave clk_out, a one-cycle clk_out_rising strobe,
// a 64-bit index of the most recent rising edge (ts_out), and the reset_out
// sync pulse that zeroes the downstream timestamp receivers.
//
// Optional feature, selected by the macro CLK_REF_GEN_AUTO_SYNC_EN:
//   defined   - every start from IDLE goes through SYNC_HOLD first, so the
//               receivers are re-zeroed and ts_out restarts at 0.
//   undefined - IDLE goes straight to RUN and edge_count keeps its value
//               across stop/start. Only sync_req or reset clears it.
//
// Sync handshake: sync_req is a one-cycle request. It is taken only while
// busy is low. While busy is high (SYNC_WAIT or SYNC_HOLD) requests are
// dropped, not queued.
module clk_ref_gen #(
   parameter int DIV_WIDTH    = 16,
   parameter int RESET_CYCLES = 4
) (
   input  logic                 sampling_clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] half_period,
   input  logic                 sync_req,
   output logic                 clk_out,
   output logic                 reset_out,
   output logic                 clk_out_rising,
   output logic [63:0]          ts_out,
   output logic                 busy
);

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

`ifdef CLK_REF_GEN_AUTO_SYNC_EN
   localparam logic AUTO_SYNC = 1'b1;
`else
   localparam logic AUTO_SYNC = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      SYNC_WAIT = 2'd2,
      SYNC_HOLD = 2'd3
   } state_t;

   state_t               state;
   logic [DIV_WIDTH-1:0] phase_cnt;
   logic [DIV_WIDTH-1:0] hp_lat;      // phase length captured at phase start
   logic [HOLD_W-1:0]    hold_cnt;
   logic [63:0]          edge_count;
   logic                 stop_pend;   // enable dropped during a high phase

   logic [DIV_WIDTH-1:0] hp_eff;
   logic                 phase_end;
   logic                 go_hold;

   // Phase length with 0 mapped to 1, end-of-phase detect, and sync entry decision
   always_comb begin
      hp_eff    = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
      phase_end = (phase_cnt == (hp_lat - DIV_WIDTH'(1)));
      go_hold   = 1'b0;
      case (state)
         // A start from IDLE also syncs when the auto-sync feature is built in
         IDLE:      go_hold = sync_req | (AUTO_SYNC & enable);
         // Wait for the high phase to finish; a low clock syncs at once
         SYNC_WAIT: go_hold = ~clk_out | phase_end;
         default:   go_hold = 1'b0;
      endcase
   end

   // Main FSM: phase counting, edge indexing, sync sequencing; all outputs registered
   always_ff @(posedge sampling_clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         clk_out        <= 1'b0;
         reset_out      <= 1'b0;
         clk_out_rising <= 1'b0;
         busy           <= 1'b0;
         ts_out         <= '0;
         edge_count     <= '0;
         phase_cnt      <= '0;
         hp_lat         <= DIV_WIDTH'(1);
         hold_cnt       <= '0;
         stop_pend      <= 1'b0;
      end else begin
         clk_out_rising <= 1'b0;
         case (state)
            IDLE: begin
               // Keep the phase primed so the first low phase is a full hp cycles
               clk_out   <= 1'b0;
               phase_cnt <= '0;
               hp_lat    <= hp_eff;
               stop_pend <= 1'b0;
               if (!go_hold && enable) begin
                  state <= RUN;
               end
            end

            RUN: begin
               if (clk_out) begin
                  // High phase always runs to completion (no runt pulses)
                  if (phase_end) begin
                     clk_out   <= 1'b0;
                     phase_cnt <= '0;
                     hp_lat    <= hp_eff;
                  end else begin
                     phase_cnt <= phase_cnt + DIV_WIDTH'(1);
                  end
                  if (!enable) begin
                     stop_pend <= 1'b1;
                  end
                  if (sync_req) begin
                     state <= SYNC_WAIT;
                     busy  <= 1'b1;
                  end else if (phase_end && (stop_pend || !enable)) begin
                     state <= IDLE;
                  end
               end else if (sync_req) begin
                  state <= SYNC_WAIT;
                  busy  <= 1'b1;
               end else if (!enable) begin
                  state <= IDLE;
               end else if (phase_end) begin
                  // Rising edge: strobe, publish this edge's index, advance the count
                  clk_out        <= 1'b1;
                  clk_out_rising <= 1'b1;
                  ts_out         <= edge_count;
                  edge_count     <= edge_count + 64'd1;
                  phase_cnt      <= '0;
                  hp_lat         <= hp_eff;
               end else begin
                  phase_cnt <= phase_cnt + DIV_WIDTH'(1);
               end
            end

            SYNC_WAIT: begin
               if (clk_out && !phase_end) begin
                  phase_cnt <= phase_cnt + DIV_WIDTH'(1);
               end
            end

            SYNC_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  // Release receivers; the next edge follows one full low phase
                  reset_out <= 1'b0;
                  busy      <= 1'b0;
                  phase_cnt <= '0;
                  hp_lat    <= hp_eff;
                  state     <= enable ? RUN : IDLE;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end

            default: state <= IDLE;
         endcase

         // Sync entry overrides whatever the state branch did this cycle
         if (go_hold) begin
            state      <= SYNC_HOLD;
            reset_out  <= 1'b1;
            busy       <= 1'b1;
            clk_out    <= 1'b0;
            edge_count <= '0;
            ts_out     <= '0;
            hold_cnt   <= '0;
            stop_pend  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_ref_gen.sv
// Bench for clk_ref_gen. Stimulus tasks push the expected rising edges
// (cycle number, ts value) into exp_q, computed from phase lengths with plain
// arithmetic; a monitor pops and compares on every clk_out_rising strobe.
`timescale 1ns/1ps
module tb_clk_ref_gen;

   localparam int DW = 16;
   localparam int RC = 4;

   // ---------------- clock / reset / DUT ----------------
   logic          sampling_clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [DW-1:0] half_period;
   logic          sync_req;
   logic          clk_out;
   logic          reset_out;
   logic          clk_out_rising;
   logic [63:0]   ts_out;
   logic          busy;

   clk_ref_gen #(.DIV_WIDTH(DW), .RESET_CYCLES(RC)) dut (
      .sampling_clk   (sampling_clk),
      .reset          (reset),
      .enable         (enable),
      .half_period    (half_period),
      .sync_req       (sync_req),
      .clk_out        (clk_out),
      .reset_out      (reset_out),
      .clk_out_rising (clk_out_rising),
      .ts_out         (ts_out),
      .busy           (busy)
   );

   always #5 sampling_clk = ~sampling_clk;

   // Count of rising sampling_clk edges; the time base for expected rises
   int unsigned cyc = 0;
   always @(posedge sampling_clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [95:0] exp_q[$];     // {cycle[31:0], ts[63:0]}
   logic [63:0] exp_ec;       // model of the emitted-edge count
   int          checks   = 0;
   int          failures = 0;
   logic [95:0] mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every rise strobe must match the oldest expected rise
   always @(negedge sampling_clk) begin
      if (!reset && clk_out_rising) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rise: got rise with ts_out=%0h at cycle %0d, required none", ts_out, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("rise_cycle", 64'(cyc), 64'(mon_e[95:64]));
            check("rise_ts", ts_out, mon_e[63:0]);
            check("rise_clk_out", 64'(clk_out), 64'd1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge sampling_clk);
         #1;
      end
   endtask

   task automatic wait_cyc(input int unsigned t);
      int k = 0;
      while (cyc < t && k < 1000) begin
         step(1);
         k++;
      end
   endtask

   task automatic push_rise(input int unsigned at);
      exp_q.push_back({at[31:0], exp_ec});
      exp_ec = exp_ec + 64'd1;
   endtask

   task automatic drain(input int bound);
      int k = 0;
      while (exp_q.size() != 0 && k < bound) begin
         step(1);
         k++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: got %0d rises pending after %0d cycles, required 0", exp_q.size(), bound);
         exp_q.delete();
      end
   endtask

   // Cycle at which RUN is entered when enable is raised now from IDLE
   function automatic int unsigned start_base();
`ifdef CLK_REF_GEN_AUTO_SYNC_EN
      exp_ec = 64'd0;
      return cyc + 1 + RC;
`else
      return cyc + 1;
`endif
   endfunction

   // From IDLE: enable with a fixed half period and expect n rises
   task automatic run_seg(input int h_in, input int n);
      int          h;
      int unsigned base;
      h = (h_in == 0) ? 1 : h_in;
      half_period = DW'(h_in);
      enable = 1'b1;
      base = start_base();
      for (int k = 0; k < n; k++) push_rise(base + h + 2 * h * k);
      drain(2 * h * n + RC + 10);
   endtask

   // Called right after a rise: drop enable, let the high phase finish
   task automatic stop_high(input int h);
      enable = 1'b0;
      step(h + 1);
      check("stopped_clk_out", 64'(clk_out), 64'd0);
      check("stopped_busy", 64'(busy), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int unsigned base;
      int unsigned r;
      int          h;
      reset = 1'b1;
      enable = 1'b0;
      sync_req = 1'b0;
      half_period = DW'(3);
      exp_ec = 64'd0;
      step(2);
      check("rst_clk_out", 64'(clk_out), 64'd0);
      check("rst_reset_out", 64'(reset_out), 64'd0);
      check("rst_rising", 64'(clk_out_rising), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ts_out", ts_out, 64'd0);
      reset = 1'b0;
      step(2);

      // hp=3 basic run, then hp=0 (period 2)
      run_seg(3, 4);
      stop_high(3);
      step(2);
      run_seg(0, 3);
      stop_high(1);

      // Randomized run/stop segments
      for (int i = 0; i < 5; i++) begin
         h = int'($urandom_range(0, 5));
         step(int'($urandom_range(1, 4)));
         run_seg(h, int'($urandom_range(2, 5)));
         stop_high((h == 0) ? 1 : h);
      end

      // hp 3 -> 5 changed mid-high phase; then enable dropped in a low phase
      step(2);
      half_period = DW'(3);
      enable = 1'b1;
      base = start_base();
      push_rise(base + 3);
      push_rise(base + 11);
      push_rise(base + 21);
      wait_cyc(base + 4);
      half_period = DW'(5);
      drain(60);
      wait_cyc(base + 27);
      check("low_before_stop", 64'(clk_out), 64'd0);
      enable = 1'b0;
      step(10);
      check("low_after_stop", 64'(clk_out), 64'd0);

      // enable dropped one cycle into a 4-cycle high phase
      run_seg(4, 1);
      step(1);
      enable = 1'b0;
      step(1);
      check("drop_high_2", 64'(clk_out), 64'd1);
      step(1);
      check("drop_high_3", 64'(clk_out), 64'd1);
      step(1);
      check("drop_fall", 64'(clk_out), 64'd0);
      step(3);
      check("drop_stays_low", 64'(clk_out), 64'd0);
      run_seg(4, 2);     // ts continues, or restarts at 0 with auto-sync
      stop_high(4);

      // sync_req during a high phase with hp=4
      step(2);
      run_seg(4, 2);
      r = cyc;
      step(1);
      sync_req = 1'b1;
      step(1);
      sync_req = 1'b0;
      check("sync_busy_wait", 64'(busy), 64'd1);
      check("sync_wait_clk_high", 64'(clk_out), 64'd1);
      step(2);
      exp_ec = 64'd0;
      for (int k = 0; k < RC; k++) begin
         check("sync_reset_out", 64'(reset_out), 64'd1);
         check("sync_busy_hold", 64'(busy), 64'd1);
         check("sync_clk_low", 64'(clk_out), 64'd0);
         check("sync_ts_zero", ts_out, 64'd0);
         sync_req = (k == 1);   // second request while busy: ignored
         step(1);
      end
      sync_req = 1'b0;
      check("sync_done_reset_out", 64'(reset_out), 64'd0);
      check("sync_done_busy", 64'(busy), 64'd0);
      push_rise(r + 12);
      drain(20);
      stop_high(4);

`ifndef CLK_REF_GEN_AUTO_SYNC_EN
      // 32-bit carry boundary of the edge count
      step(2);
      force dut.edge_count = 64'h0000_0000_FFFF_FFFE;
      step(1);
      release dut.edge_count;
      exp_ec = 64'h0000_0000_FFFF_FFFE;
      run_seg(1, 3);
      stop_high(1);
`endif

      // Asynchronous reset in the second SYNC_HOLD cycle
      step(2);
      sync_req = 1'b1;
      step(1);
      sync_req = 1'b0;
      check("idle_sync_reset_out", 64'(reset_out), 64'd1);
      check("idle_sync_busy", 64'(busy), 64'd1);
      step(1);
      check("hold2_reset_out", 64'(reset_out), 64'd1);
      reset = 1'b1;
      #1;
      check("async_reset_out", 64'(reset_out), 64'd0);
      check("async_clk_out", 64'(clk_out), 64'd0);
      check("async_busy", 64'(busy), 64'd0);
      check("async_ts_out", ts_out, 64'd0);
      exp_ec = 64'd0;
      step(1);
      reset = 1'b0;
      step(3);
      check("post_rst_clk_out", 64'(clk_out), 64'd0);
      check("post_rst_reset_out", 64'(reset_out), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_ts_out", ts_out, 64'd0);

      // Count restarts from 0 after reset
      h = int'($urandom_range(1, 4));
      run_seg(h, 3);
      stop_high(h);
      step(4);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Overall time bound
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion by 1 ms, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
